// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: show-ahead valid/ready output,
// overrun drop with a sticky overflow flag.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    input  logic              overflow_clr
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] PTR_ONE    = (ADDR_W+1)'(1);

    logic [7:0]      mem [DEPTH];
    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            rd_fire;
    logic            wr_fire;
    logic            overrun;

    assign count     = wr_ptr - rd_ptr;
    assign full      = (count == FULL_COUNT);
    assign empty     = (count == '0);
    assign out_valid = !empty;
    assign out_data  = empty ? 8'h00 : mem[rd_ptr[ADDR_W-1:0]];

    // A read in the same cycle frees the head slot, so a full FIFO can still accept.
    assign rd_fire = out_valid && out_ready;
    assign wr_fire = rx_valid && (!full || rd_fire);
    assign overrun = rx_valid && full && !rd_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            // A new overrun takes priority over a clear in the same cycle.
            if (overrun) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr[ADDR_W-1:0]] <= rx_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: vector table for basic flow, hand sequences
// for fill/overrun, full-with-read, pointer wrap, clear priority and async reset.
module tb_uart_rx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       overflow_clr;

    int checks = 0;
    int errors = 0;

    uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rv;
        logic [7:0] rd;
        logic       rdy;
        logic       clr;
        int         cnt;
        logic       ov;
        logic [7:0] od;
        logic       fl;
        logic       of;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [7:0] rd, input logic rdy, input logic clr);
        rx_valid     = rv;
        rx_data      = rd;
        out_ready    = rdy;
        overflow_clr = clr;
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic ov, input logic [7:0] od,
                             input logic fl, input logic of);
        chk({tag, ".count"},     int'(count),     cnt);
        chk({tag, ".out_valid"}, int'(out_valid), int'(ov));
        chk({tag, ".out_data"},  int'(out_data),  int'(od));
        chk({tag, ".full"},      int'(full),      int'(fl));
        chk({tag, ".empty"},     int'(empty),     (cnt == 0) ? 1 : 0);
        chk({tag, ".overflow"},  int'(overflow),  int'(of));
        $display("txn %s: count=%0d valid=%0b data=%02h full=%0b ovf=%0b",
                 tag, count, out_valid, out_data, full, overflow);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int q[$];
        int written;
        int cyc;
        int exp_head;
        logic rv;
        logic rdy;
        logic fire;

        vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 8'h11, 1'b0, 1'b0, 2, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, 1'b0};

        do_reset();
        for (int i = 0; i < 5; i++) step();
        chk_state("reset_idle", 0, 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].rv, vecs[i].rd, vecs[i].rdy, vecs[i].clr);
            step();
            chk_state($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].ov, vecs[i].od, vecs[i].fl, vecs[i].of);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to 16, then overrun with 8'hFF
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            step();
            chk("fill.count", int'(count), i + 1);
        end
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_state("overrun", 16, 1'b1, 8'h00, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            chk("drain.data", int'(out_data), i);
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_state("drained", 0, 1'b0, 8'h00, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_state("clr_idle", 0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Full with simultaneous read and write
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_state("full_rw", 16, 1'b1, 8'h01, 1'b1, 1'b0);

        // Clear and overrun together: set wins; then a lone clear
        drive(1'b1, 8'h88, 1'b0, 1'b1);
        step();
        chk_state("clr_vs_set", 16, 1'b1, 8'h01, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        step();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk_state("clr_only", 16, 1'b1, 8'h01, 1'b1, 1'b0);
        for (int i = 1; i < 17; i++) begin
            exp_head = (i == 16) ? 8'h77 : i;
            chk("full_rw.drain", int'(out_data), exp_head);
            drive(1'b0, 8'h00, 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("full_rw.empty", int'(empty), 1);

        // Pointer wrap with random occupancy against a queue model
        written = 0;
        cyc = 0;
        while ((written < 40 || q.size() > 0) && cyc < 2000) begin
            chk("wrap.count", int'(count), q.size());
            chk("wrap.data", int'(out_data), (q.size() > 0) ? q[0] : 0);
            if (count > 5'd16) begin
                errors++;
                $display("FAIL wrap.bound: count %0d exceeds 16", count);
            end
            rdy  = 1'($urandom_range(0, 1));
            rv   = (written < 40) && ($urandom_range(0, 2) != 0);
            fire = rdy && (q.size() > 0);
            if (rv && q.size() == 16 && !fire) rv = 1'b0;
            drive(rv, 8'(written * 3), rdy, 1'b0);
            step();
            if (fire) void'(q.pop_front());
            if (rv) begin
                q.push_back((written * 3) % 256);
                written++;
            end
            cyc++;
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("wrap.done", (cyc < 2000) ? 1 : 0, 1);
        chk_state("wrap_end", 0, 1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        chk("pre_rst.count", int'(count), 7);
        #2;
        rst = 1'b1;
        #1;
        chk_state("async_rst", 0, 1'b0, 8'h00, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        step();
        chk_state("post_rst", 0, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
